// File: rtl/mux4_rr_arbiter_if.sv
// Shared bus between four requesters, the round-robin arbiter and the downstream sink.
// The slave modport is the arbiter's view; the master modport is the requesters/sink view.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;

    modport master (
        output req, a, b, c, d, out_ready,
        input  out, out_valid, gnt, sel
    );

    modport slave (
        input  req, a, b, c, d, out_ready,
        output out, out_valid, gnt, sel
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with a data mux and bounded bursts.
// A grant lasts until the holder drops its request or completes BURST_MAX transfers.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int BURST_MAX = 4   // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_arbiter_if.slave     bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [3:0] cnt_q,   cnt_d;

    logic [3:0]       req_rot;
    logic [1:0]       win_off;
    logic [1:0]       winner;
    logic [WIDTH-1:0] data_arr [4];
    logic             valid_int;
    logic             xfer;

    assign data_arr[0] = bus.a;
    assign data_arr[1] = bus.b;
    assign data_arr[2] = bus.c;
    assign data_arr[3] = bus.d;

    // Rotate requests so that bit 0 is the requester at ptr; 2-bit index wraps mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi] = bus.req[ptr_q + 2'(gi)];
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 2'(i);
            end
        end
    end

    assign winner    = ptr_q + win_off;
    assign valid_int = (state_q == GRANT) && bus.req[sel_q];
    assign xfer      = valid_int && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = 4'd0;
                if (bus.req != 4'd0) begin
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    ptr_d   = sel_q + 2'd1;
                    gnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == 4'(BURST_MAX)) begin
                        ptr_d   = sel_q + 2'd1;
                        gnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_int;
    assign bus.out       = (state_q == GRANT) ? data_arr[sel_q] : '0;
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the data width of each requester and of out.
REQ-002 The block SHALL have parameter BURST_MAX, default 4, legal range 1..15, the maximum transfers per grant.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req, input, 4, request lines; bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d.
REQ-006 The block SHALL have ports a, b, c, d, input, WIDTH each, requester data.
REQ-007 The block SHALL have port out, output, WIDTH, shared data output.
REQ-008 The block SHALL have port out_valid, output, 1, out carries a valid beat.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream accepts the beat.
REQ-010 The block SHALL have port gnt, output, 4, one-hot grant, or all-zero when idle.
REQ-011 The block SHALL have port sel, output, 2, index of the granted requester (the mux select).

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and GRANT.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0 and out_valid = 0.
REQ-014 In IDLE with req != 0, the block SHALL register a winner chosen by round-robin, scanning from ptr through ptr+1, ptr+2 and ptr+3 (mod 4); first set bit wins.
REQ-015 On winning, the block SHALL load sel = winner index, set gnt = one-hot(winner), clear cnt, and enter GRANT on the next edge (grant latency: 1 cycle after req seen).
REQ-016 In GRANT, out SHALL equal a/b/c/d selected combinationally by sel.
REQ-017 In GRANT, out_valid SHALL equal req[sel].
REQ-018 In IDLE, out SHALL be all zeros.
REQ-019 A transfer SHALL occur in any cycle where out_valid && out_ready; cnt (4-bit) then increments.
REQ-020 The grant SHALL be released on the edge after either: req[sel] == 0 (no transfer that cycle), or a transfer that makes cnt reach BURST_MAX.
REQ-021 On release, the block SHALL set ptr = sel+1 (mod 4), gnt = 0, and return to IDLE; one idle cycle always separates grants.
REQ-022 out_ready == 0 with out_valid == 1 SHALL hold the grant, sel and cnt unchanged (stall, no timeout).
REQ-023 Changes on non-granted req bits during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-024 With BURST_MAX = 1, each grant SHALL carry at most one transfer.
REQ-025 No requester SHALL wait more than 3 other grants while continuously requesting (starvation-free).

Reset
REQ-026 While rst is high at a clk edge, the block SHALL force state = IDLE, gnt = 0, sel = 0, ptr = 0, cnt = 0, hence out_valid = 0 and out = 0, regardless of req or out_ready.
REQ-027 A reset asserted mid-GRANT SHALL abort the burst with no further transfers; arbitration SHALL restart from ptr = 0 on the first edge after rst falls.

Verification
REQ-028 Reset, then req = 4'b1111, out_ready = 1, a=1, b=2, c=3, d=4 -> grants a, b, c, d in order, each carrying 4 beats of its value, with 1 idle cycle between grants.
REQ-029 req = 4'b0100 only, c = 4'hA -> gnt = 4'b0100 and sel = 2 one cycle later; out = 4'hA, out_valid = 1.
REQ-030 Granted to b; hold out_ready = 0 for 3 cycles -> sel, gnt and cnt remain frozen; after out_ready rises, 4 transfers occur, then release.
REQ-031 Granted to a after 2 transfers, drop req[0] -> out_valid = 0 the same cycle, IDLE next edge, ptr = 1; pending d is granted on the following arbitration.
REQ-032 Assert rst during a GRANT to c with cnt = 2 -> next edge gnt = 0, out_valid = 0, ptr = 0; with req = 4'b1001 afterwards, a wins first.
REQ-033 BURST_MAX = 1, req = 4'b0011 held -> grants alternate a, b, a, b with exactly one transfer each.
